word_scan4: RTL
===============

Name: word_scan4

Overview:
- Four-entry, 16-bit register bank that sits directly upstream of Mux4Way16 and drives its a/b/c/d data inputs and its sel input.
- On a start pulse it snapshots the four live registers into shadow registers.
- It then streams the snapshot out one word per handshake (valid/ready), in index order 0..3.
- The Mux4Way16 sub-module selects the word being presented.

Parameters:
- RESET_VALUE, 16'h0000: reset value of all four live registers and all four shadow registers.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  write enable for the live registers
- addr  in  2  live register index for the write
- in  in  16  write data
- start  in  1  single-cycle request to snapshot and scan
- out_ready  in  1  downstream accepts the current beat
- q_a, q_b, q_c, q_d  out  16 each  live register contents (registered)
- out_data  out  16  presented snapshot word (Mux4Way16 output)
- out_sel  out  2  index of the presented word; also the sel driven into Mux4Way16
- out_valid  out  1  a beat is presented
- out_last  out  1  the presented beat is the final beat of the scan
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (async assert, sync release):
  - All live and shadow registers = RESET_VALUE.
  - State = IDLE, out_sel = 0.
  - out_valid, out_last, busy and done = 0.
- Live writes: when load=1, the register at addr takes in at the clock edge; q_* shows the new value the next cycle. Writes are allowed in any state and never disturb the shadow registers.
- States IDLE and SCAN; idx is a 2-bit register that drives out_sel.
- IDLE:
  - start=1: shadow <= live, with a same-cycle load write included (write-through), idx <= 0, state SCAN.
  - start=0: hold.
- SCAN:
  - out_valid=1, busy=1.
  - out_data = shadow[idx] through Mux4Way16; this is combinational, but stable because the shadow is frozen.
  - out_last = 1 when idx=3.
- Handshake:
  - out_valid && out_ready with idx<3: idx <= idx+1.
  - out_valid && out_ready with idx=3: state IDLE, idx <= 0, done=1 on the following cycle.
  - out_ready=0: idx, out_data and out_last hold indefinitely.
- start while in SCAN is ignored; it is not queued.
- start in the same cycle that done is high is accepted (state is IDLE by then).
- Throughput: one beat per cycle with out_ready held high. A full scan takes 4 cycles from the first out_valid, and done follows in cycle 5.
- Latency: the first beat is visible in the cycle after start is sampled.
- Reset asserted mid-scan: the scan is aborted immediately, there is no done pulse, and all outputs return to reset values.

Optional Feature:
- Macro WORD_SCAN4_SKIP_ZERO_EN.
- Defined:
  - Snapshot entries equal to 16'h0000 are never presented. idx advances to the next nonzero entry, both on start and on each handshake.
  - out_last = 1 when no nonzero entry exists above idx.
  - If all four snapshot entries are zero, start goes IDLE->SCAN->IDLE without any out_valid cycle, and done pulses 2 cycles after start.
  - Skipping is combinational (priority search), so no bubble cycles are inserted.
- Undefined: all four entries are always presented; zeros are not special.

Decomposition:
- Shared package holds:
  - Word width constant 16.
  - Index width constant 2.
  - State encoding: IDLE=0, SCAN=1.
  - Entry count constant 4.
- Sub-module: instantiate the existing Mux4Way16, with a..d = shadow[0..3], sel = idx, out = out_data. No other sub-module.

Test Plan:
- Write 16'h1111, 16'h2222, 16'h3333, 16'h4444 to addr 0..3, pulse start with out_ready=1 -> beats 1111, 2222, 3333, 4444 on consecutive cycles with out_sel 0..3, out_last only on 4444, done pulse the next cycle, busy low after.
- Start a scan, hold out_ready=0 for 5 cycles on beat 1, then release -> out_data stays 2222 and out_sel stays 1 throughout the stall; the remaining beats follow normally.
- During the scan, write addr 2 = 16'hBEEF -> q_c = BEEF next cycle, but beat 2 still shows 3333. A second scan then shows BEEF.
- Pulse start again mid-scan and in the done cycle -> the mid-scan pulse is ignored (exactly 4 beats); the done-cycle pulse starts a new scan.
- Assert rst_n=0 during beat 2 -> out_valid=0, busy=0, q_a..q_d=RESET_VALUE asynchronously, and no done pulse.
- With WORD_SCAN4_SKIP_ZERO_EN defined, regs {0, 5, 0, 7} -> beats 0005 (sel 1) and 0007 (sel 3, last). With regs all zero -> no out_valid, and done 2 cycles after start.

Source files
------------

// File: rtl/word_scan4_pkg.sv
// -----------------------------------------------------------------------------
// word_scan4_pkg
// Shared constants, state encoding and a priority-search helper for the
// word_scan4 register bank / snapshot scanner.
// -----------------------------------------------------------------------------
package word_scan4_pkg;

    localparam int WORD_W  = 16;
    localparam int IDX_W   = 2;
    localparam int ENTRIES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Lowest-indexed set bit of nz that lies above base (or at base when incl
    // is set). Result is {found, index}; index is zero when nothing is found.
    function automatic logic [IDX_W:0] next_nonzero(
        input logic [ENTRIES-1:0] nz,
        input logic [IDX_W-1:0]   base,
        input logic               incl
    );
        logic [IDX_W:0] hit;
        hit = '0;
        // Walk downward so the lowest qualifying index is the one left in hit.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (nz[i] && ((i > int'(base)) || (incl && (i == int'(base))))) begin
                hit = {1'b1, IDX_W'(i)};
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/word_scan4_mux.sv
// -----------------------------------------------------------------------------
// Mux4Way16
// Four-way, 16-bit combinational word selector.
// Ports:
//   a, b, c, d : data inputs (selected by sel = 0, 1, 2, 3)
//   sel        : select index
//   out        : selected word
// -----------------------------------------------------------------------------
module Mux4Way16
    import word_scan4_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    input  logic [IDX_W-1:0]  sel,
    output logic [WORD_W-1:0] out
);

    always_comb begin
        out = a;
        case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            2'd3:    out = d;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/word_scan4.sv
// -----------------------------------------------------------------------------
// word_scan4
// Four-entry 16-bit register bank. A start pulse snapshots the live registers
// into a shadow bank, which is then streamed out one word per valid/ready
// handshake in index order through a Mux4Way16.
//
// Build option: define WORD_SCAN4_SKIP_ZERO_EN to suppress zero-valued
// snapshot entries (priority search, no bubble cycles).
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load, addr, in    : live register write
//   start             : request snapshot + scan (ignored while scanning)
//   out_ready         : downstream accepts current beat
//   q_a..q_d          : live register contents
//   out_data, out_sel : presented snapshot word and its index
//   out_valid         : a beat is presented
//   out_last          : presented beat is the final one of the scan
//   busy              : scan in progress
//   done              : one-cycle pulse after a scan completes
// -----------------------------------------------------------------------------
module word_scan4
    import word_scan4_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VALUE = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] in,
    input  logic              start,
    input  logic              out_ready,
    output logic [WORD_W-1:0] q_a,
    output logic [WORD_W-1:0] q_b,
    output logic [WORD_W-1:0] q_c,
    output logic [WORD_W-1:0] q_d,
    output logic [WORD_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_sel,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              done_reg;
    logic              empty_reg;   // scan started with nothing to present

    logic              snap_en;
    logic [IDX_W-1:0]  adv_idx;
    logic [IDX_W-1:0]  start_idx;
    logic              start_empty;

    assign snap_en = (state_reg == ST_IDLE) && start;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);
            logic              wr_hit;
            logic [WORD_W-1:0] live_reg;
            logic [WORD_W-1:0] shadow_reg;
            logic [WORD_W-1:0] snap_next;

            assign wr_hit = load && (addr == ENTRY_IDX);
            // Same-cycle write is folded into the snapshot (write-through).
            assign snap_next = wr_hit ? in : live_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live_reg <= RESET_VALUE;
                end else if (wr_hit) begin
                    live_reg <= in;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= RESET_VALUE;
                end else if (snap_en) begin
                    shadow_reg <= snap_next;
                end
            end
        end
    endgenerate

    assign q_a = g_entry[0].live_reg;
    assign q_b = g_entry[1].live_reg;
    assign q_c = g_entry[2].live_reg;
    assign q_d = g_entry[3].live_reg;

`ifdef WORD_SCAN4_SKIP_ZERO_EN
    logic [ENTRIES-1:0] snap_nz;
    logic [ENTRIES-1:0] shadow_nz;
    logic [IDX_W:0]     first_hit;
    logic [IDX_W:0]     next_hit;

    assign snap_nz   = {|g_entry[3].snap_next, |g_entry[2].snap_next,
                        |g_entry[1].snap_next, |g_entry[0].snap_next};
    assign shadow_nz = {|g_entry[3].shadow_reg, |g_entry[2].shadow_reg,
                        |g_entry[1].shadow_reg, |g_entry[0].shadow_reg};

    // First presentable entry is searched on the incoming snapshot so the
    // first beat lands directly on it; later beats search above idx.
    assign first_hit   = next_nonzero(snap_nz, '0, 1'b1);
    assign next_hit    = next_nonzero(shadow_nz, idx_reg, 1'b0);
    assign start_idx   = first_hit[IDX_W-1:0];
    assign start_empty = !first_hit[IDX_W];
    assign adv_idx     = next_hit[IDX_W-1:0];
    assign out_valid   = (state_reg == ST_SCAN) && !empty_reg;
    assign out_last    = out_valid && !next_hit[IDX_W];
`else
    assign start_idx   = '0;
    assign start_empty = 1'b0;
    assign adv_idx     = idx_reg + 1'b1;
    assign out_valid   = (state_reg == ST_SCAN);
    assign out_last    = out_valid && (idx_reg == IDX_W'(ENTRIES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            empty_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SCAN;
                        idx_reg   <= start_idx;
                        empty_reg <= start_empty;
                    end
                end
                ST_SCAN: begin
                    if (empty_reg) begin
                        // Nothing to present: spend one cycle in SCAN, then finish.
                        state_reg <= ST_IDLE;
                        idx_reg   <= '0;
                        empty_reg <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (out_ready) begin
                        if (out_last) begin
                            state_reg <= ST_IDLE;
                            idx_reg   <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= adv_idx;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    idx_reg   <= '0;
                    empty_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_sel = idx_reg;
    assign busy    = (state_reg == ST_SCAN);
    assign done    = done_reg;

    Mux4Way16 u_mux (
        .a   (g_entry[0].shadow_reg),
        .b   (g_entry[1].shadow_reg),
        .c   (g_entry[2].shadow_reg),
        .d   (g_entry[3].shadow_reg),
        .sel (idx_reg),
        .out (out_data)
    );

endmodule
